// File: rtl/uart_tx_frame_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame_if
// Description : Byte-request / serial-line bundle for uart_tx_frame. brk exists
//               only when UART_TX_BREAK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_frame_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx_busy;
    logic            tx_done_tick;
    logic            tx;
`ifdef UART_TX_BREAK_EN
    logic            brk;

    modport master (output s_tick, tx_start, din, brk, input tx_busy, tx_done_tick, tx);
    modport slave  (input s_tick, tx_start, din, brk, output tx_busy, tx_done_tick, tx);
`else
    modport master (output s_tick, tx_start, din, input tx_busy, tx_done_tick, tx);
    modport slave  (input s_tick, tx_start, din, output tx_busy, tx_done_tick, tx);
`endif
endinterface
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame
// Description : UART transmitter: start, DBIT data bits LSB first, optional
//               parity, SB_TICK/16 stop bits. Line break via UART_TX_BREAK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame #(
    parameter int DBIT    = 8,
    parameter int PARITY  = 1,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_frame_if.slave  bus
);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [4:0]    C_BIT_LAST = 5'd15;
    localparam logic [4:0]    C_SB_LAST  = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] C_N_LAST   = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
`ifdef UART_TX_BREAK_EN
       ,S_BRK   = 3'd5
`endif
    } state_t;

    state_t          r_state;
    logic [4:0]      r_s_cnt;
    logic [NW-1:0]   r_n_cnt;
    logic [DBIT-1:0] r_shift;
    logic            r_par;
    logic            r_tx;
    logic            r_busy;
    logic            r_done;
    logic            w_par;

`ifdef UART_TX_BREAK_EN
    localparam int          BRK_TICKS   = (DBIT + 3) * 16;
    localparam int          BW          = $clog2(BRK_TICKS + 1);
    localparam logic [BW-1:0] C_BRK_MIN = BW'(BRK_TICKS);
    logic [BW-1:0] r_brk_cnt;
`endif

    assign w_par = (PARITY == 2) ? ~^bus.din : ^bus.din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_s_cnt   <= '0;
            r_n_cnt   <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_BREAK_EN
            r_brk_cnt <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
`ifdef UART_TX_BREAK_EN
                    if (bus.brk) begin
                        r_state   <= S_BRK;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_brk_cnt <= '0;
                    end else
`endif
                    if (bus.tx_start) begin
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_shift <= bus.din;
                        r_par   <= w_par;
                        r_s_cnt <= '0;
                    end
                end
                S_START: begin
                    if (bus.s_tick) begin
                        if (r_s_cnt == C_BIT_LAST) begin
                            r_state <= S_DATA;
                            r_s_cnt <= '0;
                            r_n_cnt <= '0;
                            r_tx    <= r_shift[0];
                        end else begin
                            r_s_cnt <= r_s_cnt + 5'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.s_tick) begin
                        if (r_s_cnt == C_BIT_LAST) begin
                            r_s_cnt <= '0;
                            r_shift <= r_shift >> 1;
                            if (r_n_cnt == C_N_LAST) begin
                                if (PARITY != 0) begin
                                    r_state <= S_PAR;
                                    r_tx    <= r_par;
                                end else begin
                                    r_state <= S_STOP;
                                    r_tx    <= 1'b1;
                                end
                            end else begin
                                r_n_cnt <= r_n_cnt + 1'b1;
                                // next bit is presented on the same edge the register shifts
                                r_tx    <= r_shift[1];
                            end
                        end else begin
                            r_s_cnt <= r_s_cnt + 5'd1;
                        end
                    end
                end
                S_PAR: begin
                    if (bus.s_tick) begin
                        if (r_s_cnt == C_BIT_LAST) begin
                            r_state <= S_STOP;
                            r_s_cnt <= '0;
                            r_tx    <= 1'b1;
                        end else begin
                            r_s_cnt <= r_s_cnt + 5'd1;
                        end
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (bus.s_tick) begin
                        if (r_s_cnt == C_SB_LAST) begin
                            r_state <= S_IDLE;
                            r_s_cnt <= '0;
                            r_busy  <= 1'b0;
`ifdef UART_TX_BREAK_EN
                            // a break ends through STOP too but is not a frame
                            r_done  <= (r_brk_cnt != C_BRK_MIN);
`else
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_s_cnt <= r_s_cnt + 5'd1;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                S_BRK: begin
                    r_tx <= 1'b0;
                    if (bus.s_tick) begin
                        if (r_brk_cnt == C_BRK_MIN) begin
                            if (!bus.brk) begin
                                r_state <= S_STOP;
                                r_s_cnt <= '0;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_brk_cnt <= r_brk_cnt + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
`ifdef UART_TX_BREAK_EN
            if (r_state == S_IDLE && !bus.brk && bus.tx_start)
                r_brk_cnt <= '0;
`endif
        end
    end

    assign bus.tx           = r_tx;
    assign bus.tx_busy      = r_busy;
    assign bus.tx_done_tick = r_done;

endmodule
`default_nettype wire
